dct_coef_mult_pipe: RTL and testbench
=====================================

Name: dct_coef_mult_pipe

Overview:
- Multi-lane, pipelined fixed-point multiplier that scales DCT samples by Chen cosine coefficients cos(k*pi/16), k=0..7.
- Generalises the single combinational constant multiplier:
  - LANES parallel lanes.
  - Per-lane coefficient select and negate.
  - Selectable rounding and output saturation.
  - valid/ready backpressure.
  - Tag passthrough.
- Sits between the row/column butterfly stages of the 8-point Chen DCT.

Parameters:
- IN_W, 16, signed input sample width.
- OUT_W, 16, signed output width; saturated.
- FRAC, 15, fractional bits of coefficient; 1 <= FRAC <= 30.
- CONST_W, 17, signed coefficient width; must hold 2^FRAC.
- LANES, 8, number of parallel lanes.
- TAG_W, 4, sideband tag width carried with each beat.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_data  in  LANES*IN_W  signed samples; lane i occupies bits [i*IN_W +: IN_W].
- in_sel  in  LANES*3  per-lane coefficient index k.
- in_neg  in  LANES  per-lane negate of the product.
- in_round  in  1  0 = truncate (floor), 1 = round half up; applies to the whole beat.
- in_tag  in  TAG_W  opaque sideband.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  LANES*OUT_W  signed results.
- out_sat  out  LANES  per-lane saturation occurred.
- out_tag  out  TAG_W  in_tag of the same beat.

Behaviour:
- Reset: asynchronous, active-high. Clears both stage valids, out_data, out_sat and out_tag to 0. in_ready = 1 after reset.
- Coefficients:
  - coef[k] = round-half-up(COS_Q30[k] / 2^(30-FRAC)), computed at elaboration.
  - For FRAC=15 this gives 32768, 32138, 30274, 27246, 23170, 18205, 12540, 6393.
- Stage 1, registered:
  - p = in_data_i * coef[sel_i], full IN_W+CONST_W signed.
  - If neg_i, p = -p.
  - Also registers in_round and in_tag.
- Stage 2, registered:
  - Truncate mode: r = p >>> FRAC (arithmetic shift).
  - Round mode: r = (p + 2^(FRAC-1)) >>> FRAC.
  - Widths are extended so the add cannot overflow.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. out_sat_i = 1 when clamped.
- Latency: exactly 2 cycles from acceptance to out_valid when there is no stall. Throughput is 1 beat/cycle.
- Handshake:
  - Global enable en = !out_valid || out_ready.
  - in_ready = en, a combinational function of registers and out_ready.
  - Transfer occurs when valid && ready on the same edge.
  - When en = 0, both stages hold. out_data, out_sat and out_tag stay stable while out_valid && !out_ready.
  - A bubble in stage 1 propagates as out_valid = 0. Bubbles are not compressed during a stall.
- Simultaneous accept and output on one edge are both legal: full-rate streaming.
- Reset mid-stream drops in-flight beats. The first valid output after reset comes 2 cycles after the first post-reset accept.
- sel is 3 bits, so there is no out-of-range index.
- Negating the most negative input with coef 2^FRAC saturates positive.

Decomposition:
- Package dct_coef_pkg:
  - localparam COS_Q30[0:7] = 1073741824, 1053110176, 992008094, 892783698, 759250125, 596538995, 410903207, 209476638.
  - Function coef_at(k, FRAC) returning the rounded coefficient.
  - Typedef round_mode_e {RND_TRUNC=0, RND_HALF_UP=1}.
- Sub-module dct_coef_mult_lane:
  - One lane's multiply, negate, round and saturate datapath, with stage registers gated by en.
  - The top holds the valid pipeline, handshake, tag, and a generate loop over LANES.

Test Plan:
- Reset, then lane0 in=1000, sel=4, round=0, neg=0 -> 2 cycles later out=707, sat=0. Same beat with round=1 -> 707.
- in=-1000, sel=4 -> truncate gives -708; round gives -707. With neg=1, in=1000, truncate -> -708.
- in=32767, sel=0, neg=0 -> 32767, sat=0. in=-32768, sel=0, neg=1 -> 32767, sat=1.
- Stream 8 beats with tags 0..7 and out_ready held low for cycles 3-6:
  - in_ready falls while stalled.
  - No beat is lost or duplicated.
  - Tags emerge in order.
  - out_data is stable during the stall.
- Random in_valid/out_ready at ~50% over 1000 beats, all lanes random sel/neg/round -> scoreboard matches a golden model using dct_coef_pkg.
- Assert rst for 1 cycle with 2 beats in flight -> out_valid = 0 next cycle, in_ready = 1, in-flight beats never appear.

Source files
------------

// File: rtl/dct_coef_pkg.sv
// Chen DCT cosine coefficient table and rounding-mode type shared by the
// pipelined coefficient multiplier and its lanes.
package dct_coef_pkg;

    // cos(k*pi/16) in Q30, k = 0..7
    localparam int unsigned COS_Q30 [0:7] = '{
        32'd1073741824, 32'd1053110176, 32'd992008094, 32'd892783698,
        32'd759250125,  32'd596538995,  32'd410903207, 32'd209476638
    };

    typedef enum logic {
        RND_TRUNC   = 1'b0,
        RND_HALF_UP = 1'b1
    } round_mode_e;

    function automatic logic [31:0] coef_at(input logic [2:0] k, input int frac);
        logic [31:0] acc;
        int          sh;
        sh = 30 - frac;
        if (sh > 0) begin
            acc = COS_Q30[k] + (32'd1 << (sh - 1));
        end else begin
            acc = COS_Q30[k];
        end
        return acc >> sh;
    endfunction

endpackage

// File: rtl/dct_coef_mult_lane.sv
// One lane: coefficient multiply and negate (stage 1), then round, shift and
// saturate (stage 2). Both stages advance only when en is high.
module dct_coef_mult_lane
    import dct_coef_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 16,
    parameter int FRAC    = 15,
    parameter int CONST_W = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [IN_W-1:0]  sample,
    input  logic [2:0]              sel,
    input  logic                    neg,
    input  round_mode_e             rnd,
    output logic signed [OUT_W-1:0] result,
    output logic                    sat
);

    localparam int PW = IN_W + CONST_W;
    localparam int EW = PW + 1;

    localparam logic signed [CONST_W-1:0] COEF [0:7] = '{
        CONST_W'(coef_at(3'd0, FRAC)), CONST_W'(coef_at(3'd1, FRAC)),
        CONST_W'(coef_at(3'd2, FRAC)), CONST_W'(coef_at(3'd3, FRAC)),
        CONST_W'(coef_at(3'd4, FRAC)), CONST_W'(coef_at(3'd5, FRAC)),
        CONST_W'(coef_at(3'd6, FRAC)), CONST_W'(coef_at(3'd7, FRAC))
    };

    localparam logic signed [EW-1:0] ONE  = {{(EW-1){1'b0}}, 1'b1};
    localparam logic signed [EW-1:0] HALF = ONE <<< (FRAC - 1);
    localparam logic signed [EW-1:0] MAXV = (ONE <<< (OUT_W - 1)) - ONE;
    localparam logic signed [EW-1:0] MINV = -(ONE <<< (OUT_W - 1));

    logic signed [CONST_W-1:0] coef;
    logic signed [PW-1:0]      prod;
    logic signed [PW-1:0]      prod_neg;
    logic signed [PW-1:0]      p_reg;
    logic signed [EW-1:0]      ext;
    logic signed [EW-1:0]      shifted;
    logic signed [OUT_W-1:0]   res;
    logic                      clamp;

    // Stage-1 datapath: the product magnitude is below 2^(PW-1), so negation never overflows
    always_comb begin
        coef     = COEF[sel];
        prod     = PW'(sample) * PW'(coef);
        prod_neg = neg ? -prod : prod;
    end

    // Stage-2 datapath: one guard bit keeps the rounding add exact
    always_comb begin
        ext = EW'(p_reg);
        if (rnd == RND_HALF_UP) begin
            ext = ext + HALF;
        end else begin
            ext = EW'(p_reg);
        end
        shifted = ext >>> FRAC;
        if (shifted > MAXV) begin
            res   = MAXV[OUT_W-1:0];
            clamp = 1'b1;
        end else if (shifted < MINV) begin
            res   = MINV[OUT_W-1:0];
            clamp = 1'b1;
        end else begin
            res   = shifted[OUT_W-1:0];
            clamp = 1'b0;
        end
    end

    // Stage registers, held while the pipeline is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_reg  <= {PW{1'b0}};
            result <= {OUT_W{1'b0}};
            sat    <= 1'b0;
        end else if (en) begin
            p_reg  <= prod_neg;
            result <= res;
            sat    <= clamp;
        end
    end

endmodule

// File: rtl/dct_coef_mult_pipe.sv
// Multi-lane two-stage DCT coefficient multiplier with valid/ready flow control;
// a single enable stalls every lane, the valid pipeline and the tag together.
module dct_coef_mult_pipe
    import dct_coef_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 16,
    parameter int FRAC    = 15,
    parameter int CONST_W = 17,
    parameter int LANES   = 8,
    parameter int TAG_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic [LANES*3-1:0]     in_sel,
    input  logic [LANES-1:0]       in_neg,
    input  logic                   in_round,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [LANES-1:0]       out_sat,
    output logic [TAG_W-1:0]       out_tag
);

    logic              en;
    logic              s1_valid;
    round_mode_e       s1_round;
    logic [TAG_W-1:0]  s1_tag;

    // Global pipeline enable: advance unless a held output is being refused
    always_comb begin
        en       = !out_valid || out_ready;
        in_ready = en;
    end

    // Valid, round-mode and tag pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            s1_round  <= RND_TRUNC;
            s1_tag    <= {TAG_W{1'b0}};
            out_tag   <= {TAG_W{1'b0}};
        end else if (en) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            s1_round  <= round_mode_e'(in_round);
            s1_tag    <= in_tag;
            out_tag   <= s1_tag;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dct_coef_mult_lane #(
            .IN_W    (IN_W),
            .OUT_W   (OUT_W),
            .FRAC    (FRAC),
            .CONST_W (CONST_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .sample (in_data[i*IN_W +: IN_W]),
            .sel    (in_sel[i*3 +: 3]),
            .neg    (in_neg[i]),
            .rnd    (s1_round),
            .result (out_data[i*OUT_W +: OUT_W]),
            .sat    (out_sat[i])
        );
    end

endmodule

// File: tb/tb_dct_coef_mult_pipe.sv
// Randomized and directed bench for dct_coef_mult_pipe with a scoreboard fed
// by an arithmetic reference model of the scaled, rounded, saturated product.
module tb_dct_coef_mult_pipe;

    localparam int LANES = 8;
    localparam int IN_W  = 16;
    localparam int OUT_W = 16;
    localparam int TAG_W = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_data = '0;
    logic [LANES*3-1:0]     in_sel = '0;
    logic [LANES-1:0]       in_neg = '0;
    logic                   in_round = 1'b0;
    logic [TAG_W-1:0]       in_tag = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [LANES*OUT_W-1:0] out_data;
    logic [LANES-1:0]       out_sat;
    logic [TAG_W-1:0]       out_tag;

    dct_coef_mult_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_neg    (in_neg),
        .in_round  (in_round),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // Q15 cosine coefficients cos(k*pi/16) * 2^15, rounded
    int coef_tab [8] = '{32768, 32138, 30274, 27246, 23170, 18205, 12540, 6393};

    typedef struct {
        logic [LANES*OUT_W-1:0] data;
        logic [LANES-1:0]       sat;
        logic [TAG_W-1:0]       tag;
        int                     cyc;
    } beat_t;

    beat_t sb [$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int delivered = 0;
    bit strict = 1'b0;
    bit held_prev = 1'b0;
    logic [LANES*OUT_W-1:0] held_data;
    logic [TAG_W-1:0]       held_tag;
    logic [LANES*OUT_W-1:0] last_data = '0;
    logic [LANES-1:0]       last_sat = '0;

    logic [LANES*IN_W-1:0]  b_data = '0;
    logic [LANES*3-1:0]     b_sel = '0;
    logic [LANES-1:0]       b_neg = '0;
    logic                   b_round = 1'b0;
    logic [TAG_W-1:0]       b_tag = '0;

    task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // floor(x * cos(k*pi/16)) or floor(x*cos + 1/2) in Q15, clamped to 16 bits
    function automatic beat_t model_beat();
        beat_t b;
        for (int i = 0; i < LANES; i++) begin
            logic signed [IN_W-1:0] x;
            longint p;
            longint q;
            x = b_data[i*IN_W +: IN_W];
            p = longint'(x) * longint'(coef_tab[b_sel[i*3 +: 3]]);
            if (b_neg[i]) p = -p;
            if (b_round) p = p + 64'sd16384;
            q = p / 64'sd32768;
            if (p < 0 && (p % 64'sd32768) != 0) q = q - 64'sd1;
            if (q > 64'sd32767) begin
                b.data[i*OUT_W +: OUT_W] = 16'h7fff;
                b.sat[i] = 1'b1;
            end else if (q < -64'sd32768) begin
                b.data[i*OUT_W +: OUT_W] = 16'h8000;
                b.sat[i] = 1'b1;
            end else begin
                b.data[i*OUT_W +: OUT_W] = 16'(q);
                b.sat[i] = 1'b0;
            end
        end
        b.tag = b_tag;
        b.cyc = 0;
        return b;
    endfunction

    task automatic randomize_beat();
        b_data  = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < LANES; i++) begin
            if ($urandom_range(0, 7) == 0) b_data[i*IN_W +: IN_W] = 16'h8000;
            else if ($urandom_range(0, 7) == 0) b_data[i*IN_W +: IN_W] = 16'h7fff;
        end
        b_sel   = 24'($urandom);
        b_neg   = 8'($urandom);
        b_round = 1'($urandom);
        b_tag   = 4'($urandom);
    endtask

    // One clock cycle: drive at the falling edge, observe 1 time unit later
    task automatic cycle(input bit iv, input bit ordy, output bit acc);
        beat_t e;
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        in_data   = b_data;
        in_sel    = b_sel;
        in_neg    = b_neg;
        in_round  = b_round;
        in_tag    = b_tag;
        #1;
        cyc++;
        if (held_prev) begin
            check_val("hold_data", out_data, held_data);
            check_val("hold_tag", out_tag, held_tag);
        end
        if (out_valid && !out_ready) check_val("in_ready_stall", in_ready, 1'b0);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_val("spurious_out", out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check_val("out_data", out_data, e.data);
                check_val("out_sat", out_sat, e.sat);
                check_val("out_tag", out_tag, e.tag);
                if (strict) check_val("latency", cyc - e.cyc, 2);
                last_data = out_data;
                last_sat  = out_sat;
                delivered++;
            end
        end
        acc = in_valid && in_ready;
        if (acc) begin
            e = model_beat();
            e.cyc = cyc;
            sb.push_back(e);
        end
        held_prev = out_valid && !out_ready;
        held_data = out_data;
        held_tag  = out_tag;
    endtask

    task automatic drain();
        bit a;
        for (int j = 0; j < 20 && sb.size() > 0; j++) cycle(1'b0, 1'b1, a);
        if (sb.size() != 0) begin
            check_val("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic directed(input string name, input int x, input int k, input bit n, input bit r,
                            input int exp_y, input bit exp_s);
        bit a;
        logic [15:0] ey;
        ey = 16'(exp_y);
        b_data = '0;
        b_data[15:0] = 16'(x);
        b_sel = '0;
        b_sel[2:0] = 3'(k);
        b_neg = '0;
        b_neg[0] = n;
        b_round = r;
        b_tag = 4'($urandom);
        strict = 1'b1;
        cycle(1'b1, 1'b1, a);
        check_val({name, "_accept"}, a, 1'b1);
        drain();
        check_val({name, "_y"}, last_data[15:0], ey);
        check_val({name, "_sat"}, last_sat[0], exp_s);
        strict = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        int sent;
        int base;
        int c;

        repeat (2) @(negedge clk);
        #1;
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_in_ready", in_ready, 1'b1);
        check_val("rst_out_data", out_data, '0);
        check_val("rst_out_sat", out_sat, '0);
        check_val("rst_out_tag", out_tag, '0);
        @(negedge clk);
        rst = 1'b0;

        directed("pos_trunc", 1000, 4, 1'b0, 1'b0, 707, 1'b0);
        directed("pos_round", 1000, 4, 1'b0, 1'b1, 707, 1'b0);
        directed("neg_trunc", -1000, 4, 1'b0, 1'b0, -708, 1'b0);
        directed("neg_round", -1000, 4, 1'b0, 1'b1, -707, 1'b0);
        directed("negate_trunc", 1000, 4, 1'b1, 1'b0, -708, 1'b0);
        directed("max_unity", 32767, 0, 1'b0, 1'b0, 32767, 1'b0);
        directed("min_negated", -32768, 0, 1'b1, 1'b0, 32767, 1'b1);

        // Eight tagged beats with the output refused for cycles 3..6
        sent = 0;
        base = delivered;
        b_tag = 4'd0;
        randomize_beat();
        b_tag = 4'd0;
        for (c = 0; c < 40 && (sent < 8 || sb.size() > 0); c++) begin
            cycle(sent < 8, !(c >= 3 && c <= 6), a);
            if (a) begin
                sent++;
                randomize_beat();
                b_tag = 4'(sent);
            end
        end
        check_val("stall_sent", sent, 8);
        check_val("stall_delivered", delivered - base, 8);
        sb.delete();

        // Random flow control on both sides
        sent = 0;
        base = delivered;
        randomize_beat();
        for (c = 0; c < 6000 && sent < 1000; c++) begin
            cycle(1'($urandom), 1'($urandom), a);
            if (a) begin
                sent++;
                randomize_beat();
            end
        end
        check_val("rand_sent", sent, 1000);
        drain();
        check_val("rand_delivered", delivered - base, 1000);

        // Reset with two beats in flight
        randomize_beat();
        cycle(1'b1, 1'b1, a);
        randomize_beat();
        cycle(1'b1, 1'b1, a);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rstmid_out_valid", out_valid, 1'b0);
        check_val("rstmid_in_ready", in_ready, 1'b1);
        sb.delete();
        held_prev = 1'b0;
        for (int j = 0; j < 5; j++) cycle(1'b0, 1'b1, a);
        directed("post_reset", 1000, 4, 1'b0, 1'b0, 707, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
